// File: rtl/cpu_core_param.sv
// Parametrised accumulator-style CPU core: req/ack instruction and data ports,
// valid/ready output port, four registers, Z/C flags and a HALT state.
module cpu_core_param #(
  parameter int WIDTH = 8,
  parameter int AW = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imemReq,
  output logic [AW-1:0]    imemAddr,
  input  logic             imemAck,
  input  logic [WIDTH-1:0] imemData,
  output logic             dmemReq,
  output logic             dmemWe,
  output logic [AW-1:0]    dmemAddr,
  output logic [WIDTH-1:0] dmemWdata,
  input  logic             dmemAck,
  input  logic [WIDTH-1:0] dmemRdata,
  output logic             outValid,
  output logic [WIDTH-1:0] outData,
  input  logic             outReady,
  output logic             halted
);
  // state   | meaning
  // stFetch | request instruction at pc
  // stExec  | decode; register ops complete here
  // stImm   | request immediate / jump target at pc
  // stMem   | load or store in flight
  // stOut   | offer rd on output port
  // stHalt  | stopped until reset
  localparam logic [2:0] stFetch = 3'd0;
  localparam logic [2:0] stExec  = 3'd1;
  localparam logic [2:0] stImm   = 3'd2;
  localparam logic [2:0] stMem   = 3'd3;
  localparam logic [2:0] stOut   = 3'd4;
  localparam logic [2:0] stHalt  = 3'd5;

  localparam logic [2:0] opLdi = 3'b000;
  localparam logic [2:0] opMov = 3'b001;
  localparam logic [2:0] opAdd = 3'b010;
  localparam logic [2:0] opSub = 3'b011;
  localparam logic [2:0] opLd  = 3'b100;
  localparam logic [2:0] opSt  = 3'b101;
  localparam logic [2:0] opJmp = 3'b110;

  logic [2:0]       state;
  logic [AW-1:0]    pc;
  logic [WIDTH-1:0] regs [4];
  logic             zFlag;
  logic             cFlag;
  logic [7:0]       ir;

  logic [2:0]       op;
  logic [1:0]       rd;
  logic [1:0]       rs;
  logic [WIDTH-1:0] rdVal;
  logic [WIDTH-1:0] rsVal;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             jmpTaken;

  assign op    = ir[7:5];
  assign rd    = ir[4:3];
  assign rs    = ir[2:1];
  assign rdVal = regs[rd];
  assign rsVal = regs[rs];
  assign sum   = {1'b0, rdVal} + {1'b0, rsVal};
  // carry out of rd + ~rs + 1 is set exactly when no borrow occurs (rd >= rs)
  assign diff  = {1'b0, rdVal} + {1'b0, ~rsVal} + {{WIDTH{1'b0}}, 1'b1};

  // Flags only move in EXEC of ADD/SUB, so reading them in IMM matches the JMP's EXEC view.
  always_comb begin
    jmpTaken = 1'b0;
    case (rd)
      2'b00: jmpTaken = 1'b1;
      2'b01: jmpTaken = zFlag;
      2'b10: jmpTaken = cFlag;
      default: jmpTaken = !zFlag;
    endcase
  end

  assign imemReq   = !reset && (state == stFetch || state == stImm);
  assign imemAddr  = pc;
  assign dmemReq   = !reset && (state == stMem);
  assign dmemWe    = (op == opSt);
  assign dmemAddr  = AW'(rsVal);
  assign dmemWdata = rdVal;
  assign outValid  = !reset && (state == stOut);
  assign outData   = rdVal;
  assign halted    = !reset && (state == stHalt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= stFetch;
      pc    <= RESET_PC;
      zFlag <= 1'b0;
      cFlag <= 1'b0;
      ir    <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        stFetch: if (imemAck) begin
          ir    <= imemData[7:0];
          pc    <= pc + AW'(1);
          state <= stExec;
        end
        stExec: begin
          state <= stFetch;
          case (op)
            opMov: regs[rd] <= rsVal;
            opAdd: begin
              regs[rd] <= sum[WIDTH-1:0];
              cFlag    <= sum[WIDTH];
              zFlag    <= (sum[WIDTH-1:0] == '0);
            end
            opSub: begin
              regs[rd] <= diff[WIDTH-1:0];
              cFlag    <= diff[WIDTH];
              zFlag    <= (diff[WIDTH-1:0] == '0);
            end
            opLdi, opJmp: state <= stImm;
            opLd, opSt:   state <= stMem;
            default:      state <= ir[0] ? stHalt : stOut;
          endcase
        end
        stImm: if (imemAck) begin
          state <= stFetch;
          if (op == opLdi) begin
            regs[rd] <= imemData;
            pc       <= pc + AW'(1);
          end else if (jmpTaken) begin
            pc <= AW'(imemData);
          end else begin
            pc <= pc + AW'(1);
          end
        end
        stMem: if (dmemAck) begin
          if (!dmemWe) regs[rd] <= dmemRdata;
          state <= stFetch;
        end
        stOut: if (outReady) state <= stFetch;
        stHalt: state <= stHalt;
        default: state <= stFetch;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: 8-bit core against an instruction-level model with
// randomised programs and slave latencies, plus a 16-bit/12-bit address instance.
module tb_cpu_core_param;
  logic        clk;
  logic        reset;
  logic        imemReq, imemAck, dmemReq, dmemWe, dmemAck, outValid, outReady, halted;
  logic [7:0]  imemAddr, imemData, dmemAddr, dmemWdata, dmemRdata, outData;

  logic        resetB;
  logic        imemReqB, imemAckB, dmemReqB, dmemWeB, dmemAckB, outValidB, outReadyB, haltedB;
  logic [11:0] imemAddrB, dmemAddrB;
  logic [15:0] imemDataB, dmemWdataB, dmemRdataB, outDataB;

  int testCount = 0;
  int failCount = 0;

  logic [7:0]  prog  [256];
  logic [7:0]  dmemA [256];
  logic [7:0]  mdm   [256];
  logic [15:0] memB  [4096];

  logic [7:0]  fetchLog [$];
  logic [7:0]  outLog   [$];
  int          storeLog [$];
  int          loadCount;
  logic [11:0] fetchB [$];
  logic [15:0] outB   [$];

  int expFetch [$];
  int expOut   [$];
  int expSt    [$];
  int expCycles;

  int iMaxWait, dMaxWait, dFixed, outFixed;
  bit iStall, noise;

  cpu_core_param #(.WIDTH(8), .AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
    .dmemAck(dmemAck), .dmemRdata(dmemRdata),
    .outValid(outValid), .outData(outData), .outReady(outReady), .halted(halted)
  );

  cpu_core_param #(.WIDTH(16), .AW(12), .RESET_PC(12'hFFD)) dutB (
    .clk(clk), .reset(resetB),
    .imemReq(imemReqB), .imemAddr(imemAddrB), .imemAck(imemAckB), .imemData(imemDataB),
    .dmemReq(dmemReqB), .dmemWe(dmemWeB), .dmemAddr(dmemAddrB), .dmemWdata(dmemWdataB),
    .dmemAck(dmemAckB), .dmemRdata(dmemRdataB),
    .outValid(outValidB), .outData(outDataB), .outReady(outReadyB), .halted(haltedB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slaves answer on the falling edge; a handshake logged here completes on the next rising edge.
  initial begin : imemSlave
    int wt;
    logic pend;
    logic [7:0] hAddr;
    pend = 1'b0; imemAck = 1'b0; imemData = '0; wt = 0; hAddr = '0;
    forever begin
      @(negedge clk);
      if (imemReq) begin
        if (!pend) begin
          pend = 1'b1;
          wt = iStall ? (1 << 30) : int'($urandom_range(0, iMaxWait));
          hAddr = imemAddr;
        end else chk("imemAddrStable", 32'(imemAddr), 32'(hAddr));
        if (wt == 0) begin
          imemAck = 1'b1; imemData = prog[imemAddr];
          fetchLog.push_back(imemAddr); pend = 1'b0;
        end else begin
          imemAck = 1'b0; imemData = 8'($urandom); wt--;
        end
      end else begin
        pend = 1'b0;
        imemAck = noise ? 1'($urandom) : 1'b0;
        imemData = 8'($urandom);
      end
    end
  end

  initial begin : dmemSlave
    int wt;
    logic pend, hWe;
    logic [7:0] hAddr, hData;
    pend = 1'b0; dmemAck = 1'b0; dmemRdata = '0; wt = 0; hWe = 1'b0; hAddr = '0; hData = '0;
    forever begin
      @(negedge clk);
      if (dmemReq) begin
        if (!pend) begin
          pend = 1'b1;
          wt = (dFixed >= 0) ? dFixed : int'($urandom_range(0, dMaxWait));
          hAddr = dmemAddr; hWe = dmemWe; hData = dmemWdata;
        end else begin
          chk("dmemAddrStable", 32'(dmemAddr), 32'(hAddr));
          chk("dmemWeStable", 32'(dmemWe), 32'(hWe));
          chk("dmemWdataStable", 32'(dmemWdata), 32'(hData));
        end
        if (wt == 0) begin
          dmemAck = 1'b1; pend = 1'b0;
          if (dmemWe) begin
            dmemA[dmemAddr] = dmemWdata;
            storeLog.push_back(32'({dmemAddr, dmemWdata}));
          end else begin
            dmemRdata = dmemA[dmemAddr];
            loadCount++;
          end
        end else begin
          dmemAck = 1'b0; dmemRdata = 8'($urandom); wt--;
        end
      end else begin
        pend = 1'b0;
        dmemAck = noise ? 1'($urandom) : 1'b0;
        dmemRdata = 8'($urandom);
      end
    end
  end

  initial begin : outSink
    int wt;
    logic pend;
    logic [7:0] hData;
    pend = 1'b0; outReady = 1'b0; wt = 0; hData = '0;
    forever begin
      @(negedge clk);
      if (outValid) begin
        if (!pend) begin
          pend = 1'b1;
          wt = (outFixed >= 0) ? outFixed : int'($urandom_range(0, 3));
          hData = outData;
        end else chk("outDataStable", 32'(outData), 32'(hData));
        if (wt == 0) begin
          outReady = 1'b1; outLog.push_back(outData); pend = 1'b0;
        end else begin
          outReady = 1'b0; wt--;
        end
      end else begin
        pend = 1'b0;
        outReady = noise ? 1'($urandom) : 1'b0;
      end
    end
  end

  initial begin : sideB
    imemAckB = 1'b0; imemDataB = '0; dmemAckB = 1'b0; dmemRdataB = '0; outReadyB = 1'b0;
    forever begin
      @(negedge clk);
      imemAckB = imemReqB;
      imemDataB = memB[imemAddrB];
      if (imemReqB) fetchB.push_back(imemAddrB);
      dmemAckB = dmemReqB;
      outReadyB = 1'b1;
      if (outValidB) outB.push_back(outDataB);
    end
  end

  // Instruction-level reference: executes prog[] from address 0 until HALT.
  task automatic runModel();
    int r [4];
    int pc, ir, op, rd, rs, a, b, s, steps;
    bit z, c, taken;
    r = '{0, 0, 0, 0};
    z = 0; c = 0; pc = 0; expCycles = 0;
    expFetch.delete(); expOut.delete(); expSt.delete();
    for (steps = 0; steps < 1000; steps++) begin
      expFetch.push_back(pc);
      ir = int'(prog[pc]);
      pc = (pc + 1) % 256;
      op = ir / 32; rd = (ir / 8) % 4; rs = (ir / 2) % 4;
      a = r[rd]; b = r[rs];
      if (op == 7 && ir % 2 == 1) begin
        expCycles += 2;
        break;
      end
      case (op)
        0: begin expFetch.push_back(pc); r[rd] = int'(prog[pc]); pc = (pc + 1) % 256; expCycles += 3; end
        1: begin r[rd] = b; expCycles += 2; end
        2: begin s = a + b; c = (s > 255); r[rd] = s % 256; z = (r[rd] == 0); expCycles += 2; end
        3: begin c = (a >= b); r[rd] = (a - b + 256) % 256; z = (r[rd] == 0); expCycles += 2; end
        4: begin r[rd] = int'(mdm[b]); expCycles += 3; end
        5: begin mdm[b] = 8'(a); expSt.push_back(b * 256 + a); expCycles += 3; end
        6: begin
          taken = (rd == 0) || (rd == 1 && z) || (rd == 2 && c) || (rd == 3 && !z);
          expFetch.push_back(pc);
          pc = taken ? int'(prog[pc]) : (pc + 1) % 256;
          expCycles += 3;
        end
        default: begin expOut.push_back(a); expCycles += 3; end
      endcase
    end
  endtask

  function automatic logic [7:0] aluByte();
    logic [7:0] v;
    v = 8'($urandom);
    case ($urandom_range(0, 3))
      0: v[7:5] = 3'b001;
      1: v[7:5] = 3'b010;
      2: v[7:5] = 3'b011;
      default: begin v[7:5] = 3'b111; v[0] = 1'b0; end
    endcase
    return v;
  endfunction

  task automatic clearProg();
    for (int i = 0; i < 256; i++) prog[i] = 8'hE1;
  endtask

  // Random code; every jump lands a few single-byte instructions ahead so both paths converge.
  task automatic genProgram();
    int a, k, skip;
    logic [7:0] v;
    clearProg();
    a = 0;
    while (a < 200) begin
      k = int'($urandom_range(0, 9));
      v = 8'($urandom);
      if (k <= 1) begin
        v[7:5] = 3'b000; prog[a] = v; prog[a+1] = 8'($urandom); a += 2;
      end else if (k <= 5) begin
        prog[a] = aluByte(); a++;
      end else if (k == 6) begin
        v[7:5] = 3'b100; prog[a] = v; a++;
      end else if (k == 7) begin
        v[7:5] = 3'b101; prog[a] = v; a++;
      end else begin
        skip = int'($urandom_range(0, 3));
        v[7:5] = 3'b110; prog[a] = v; prog[a+1] = 8'(a + 2 + skip); a += 2;
        for (int s = 0; s < skip; s++) begin prog[a] = aluByte(); a++; end
      end
    end
    v = 8'($urandom); v[7:5] = 3'b111; v[0] = 1'b1;
    prog[a] = v;
  endtask

  task automatic runProgram(input string tag, input bit checkCycles);
    int cyc;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    fetchLog.delete(); storeLog.delete(); outLog.delete(); loadCount = 0;
    for (int i = 0; i < 256; i++) mdm[i] = dmemA[i];
    runModel();
    @(posedge clk); #1 reset = 1'b0;
    cyc = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      if (halted) break;
      cyc++;
    end
    chk({tag, ".halted"}, 32'(halted), 32'd1);
    if (checkCycles) chk({tag, ".cycles"}, 32'(cyc), 32'(expCycles));
    if (fetchLog.size() > 0) chk({tag, ".firstFetch"}, 32'(fetchLog[0]), 32'h00);
    chk({tag, ".fetchCount"}, 32'(fetchLog.size()), 32'(expFetch.size()));
    for (int i = 0; i < fetchLog.size() && i < expFetch.size(); i++)
      chk($sformatf("%s.fetch[%0d]", tag, i), 32'(fetchLog[i]), 32'(expFetch[i]));
    chk({tag, ".outCount"}, 32'(outLog.size()), 32'(expOut.size()));
    for (int i = 0; i < outLog.size() && i < expOut.size(); i++)
      chk($sformatf("%s.out[%0d]", tag, i), 32'(outLog[i]), 32'(expOut[i]));
    chk({tag, ".storeCount"}, 32'(storeLog.size()), 32'(expSt.size()));
    for (int i = 0; i < storeLog.size() && i < expSt.size(); i++)
      chk($sformatf("%s.store[%0d]", tag, i), 32'(storeLog[i]), 32'(expSt[i]));
    repeat (20) begin
      @(negedge clk);
      chk({tag, ".haltQuiet"}, 32'({imemReq, dmemReq, outValid, halted}), 32'h1);
    end
  endtask

  initial begin : main
    int cyc;
    reset = 1'b1; resetB = 1'b1;
    iMaxWait = 0; dMaxWait = 0; dFixed = -1; outFixed = 0; iStall = 1'b1; noise = 1'b0;
    for (int i = 0; i < 256; i++) dmemA[i] = 8'($urandom);
    clearProg();

    // Reset while a fetch is pending and never acknowledged.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("pendingFetch", 32'(imemReq), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("resetQuiet", 32'({imemReq, dmemReq, outValid, halted}), 32'h0);
      @(posedge clk);
    end
    iStall = 1'b0;

    // LDI r0,#FF; LDI r1,#01; ADD r0,r1; JMP Z,#20; (0x20) OUT r0; HALT
    clearProg();
    prog[0] = 8'h00; prog[1] = 8'hFF; prog[2] = 8'h08; prog[3] = 8'h01;
    prog[4] = 8'h42; prog[5] = 8'hC8; prog[6] = 8'h20;
    prog[8'h20] = 8'hE0; prog[8'h21] = 8'hE1;
    runProgram("addJmpZ", 1'b1);
    if (fetchLog.size() > 7) chk("addJmpZ.target", 32'(fetchLog[7]), 32'h20);
    if (outLog.size() > 0) chk("addJmpZ.outVal", 32'(outLog[0]), 32'h00);
    chk("addJmpZ.cycles16", 32'(expCycles), 32'd16);

    // LDI r0,#03; LDI r1,#05; SUB r0,r1; JMP C,#40; OUT r0; HALT
    clearProg();
    prog[0] = 8'h00; prog[1] = 8'h03; prog[2] = 8'h08; prog[3] = 8'h05;
    prog[4] = 8'h62; prog[5] = 8'hD0; prog[6] = 8'h40; prog[7] = 8'hE0; prog[8] = 8'hE1;
    prog[8'h40] = 8'hE8;
    runProgram("subJmpC", 1'b1);
    if (fetchLog.size() > 7) chk("subJmpC.notTaken", 32'(fetchLog[7]), 32'h07);
    if (outLog.size() > 0) chk("subJmpC.outVal", 32'(outLog[0]), 32'hFE);

    // Slow data and output slaves: ST r2->[r3], LD r1<-[r3], OUT r1
    clearProg();
    prog[0] = 8'h10; prog[1] = 8'hA5; prog[2] = 8'h18; prog[3] = 8'h10;
    prog[4] = 8'hB6; prog[5] = 8'h8E; prog[6] = 8'hE8; prog[7] = 8'hE1;
    dFixed = 4; outFixed = 5;
    runProgram("memSlow", 1'b0);
    chk("memSlow.loads", 32'(loadCount), 32'd1);
    if (storeLog.size() > 0) chk("memSlow.store", 32'(storeLog[0]), 32'h10A5);
    if (outLog.size() > 0) chk("memSlow.outVal", 32'(outLog[0]), 32'hA5);
    dFixed = -1; outFixed = 0;

    for (int it = 0; it < 8; it++) begin
      genProgram();
      for (int i = 0; i < 256; i++) dmemA[i] = 8'($urandom);
      noise = 1'($urandom);
      if (it % 3 == 0) begin
        iMaxWait = 0; dMaxWait = 0; dFixed = -1; outFixed = 0;
        runProgram($sformatf("rand%0d", it), 1'b1);
      end else begin
        iMaxWait = int'($urandom_range(0, 3)); dMaxWait = int'($urandom_range(0, 4));
        dFixed = -1; outFixed = -1;
        runProgram($sformatf("rand%0d", it), 1'b0);
      end
    end
    noise = 1'b0;

    // Wide instance: 16-bit data, 12-bit pc wrapping from FFF to 000.
    for (int i = 0; i < 4096; i++) memB[i] = 16'hA5E1;
    memB[12'hFFD] = 16'h3C00; memB[12'hFFE] = 16'hFFFF;
    memB[12'hFFF] = 16'h7708; memB[12'h000] = 16'h0001;
    memB[12'h001] = 16'h1242; memB[12'h002] = 16'h00C8; memB[12'h003] = 16'hF123;
    memB[12'h123] = 16'h00E0; memB[12'h124] = 16'h00D0; memB[12'h125] = 16'h0200;
    memB[12'h200] = 16'h00E8; memB[12'h201] = 16'h00E1;
    fetchB.delete(); outB.delete();
    @(posedge clk); #1 resetB = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (haltedB) break;
      cyc++;
    end
    chk("wide.halted", 32'(haltedB), 32'd1);
    chk("wide.fetchCount", 32'(fetchB.size()), 32'd12);
    if (fetchB.size() >= 12) begin
      chk("wide.firstFetch", 32'(fetchB[0]), 32'hFFD);
      chk("wide.fetchFFF", 32'(fetchB[2]), 32'hFFF);
      chk("wide.wrap", 32'(fetchB[3]), 32'h000);
      chk("wide.jmpZ", 32'(fetchB[7]), 32'h123);
      chk("wide.jmpC", 32'(fetchB[10]), 32'h200);
    end
    chk("wide.outCount", 32'(outB.size()), 32'd2);
    if (outB.size() >= 2) begin
      chk("wide.sum", 32'(outB[0]), 32'h0000);
      chk("wide.r1", 32'(outB[1]), 32'h0001);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
